// File: rtl/rrb_pkg.sv
// rrb_pkg: shared state type and index/weight helpers for the weighted round-robin arbiter
package rrb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int wsl_lo(input int k, input int width);
    return k * width;
  endfunction
  function automatic logic [5:0] oh2idx(input logic [63:0] oh);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r |= oh[i] ? 6'(i) : 6'd0;
    return r;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: rotating-priority search starting after ptr_i; req_i candidates, mask_i drops req_i[ptr_i]; win_o one-hot, idx_o binary, found_o any
module rr_priority_picker
  import rrb_pkg::*;
#(
  parameter int CHANNELS = 8,
  localparam int IDW = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IDW-1:0]      ptr_i,
  input  logic                mask_i,
  output logic [CHANNELS-1:0] win_o,
  output logic [IDW-1:0]      idx_o,
  output logic                found_o
);
  logic [CHANNELS-1:0] cand;
  logic [IDW-1:0] c;
  always_comb begin
    cand = req_i & ~(CHANNELS'(mask_i) << ptr_i);
    win_o = '0;
    c = '0;
    // walk from farthest to nearest so the channel right after ptr_i wins
    for (int i = CHANNELS; i >= 1; i--) begin
      c = IDW'((int'(ptr_i) + i) % CHANNELS);
      if (cand[c]) win_o = CHANNELS'(1) << c;
    end
    found_o = |win_o;
    idx_o = IDW'(oh2idx(64'(win_o)));
  end
endmodule

// File: rtl/wrr_arbiter_param.sv
// wrr_arbiter_param: weighted round-robin arbiter; request/weight/wrr_en in, registered grant/grant_id out, grant_valid and quantum_last status
module wrr_arbiter_param
  import rrb_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH = 32,
  localparam int IDW = idx_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       request,
  input  logic [CHANNELS*WIDTH-1:0] weight,
  input  logic                      wrr_en,
  output logic [CHANNELS-1:0]       grant,
  output logic [IDW-1:0]            grant_id,
  output logic                      grant_valid,
  output logic                      quantum_last
);
  state_e state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d, win;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, win_id, pick_ptr;
  logic [WIDTH-1:0] rem_q, rem_d, load;
  logic [WIDTH-1:0] w_arr [CHANNELS];
  logic found, rel, take, hold, mask;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_w
    assign w_arr[g] = weight[wsl_lo(g, WIDTH) +: WIDTH];
  end
  // while granting, search after the holder; masking it only matters when others wait
  assign pick_ptr = (state_q == GRANT) ? id_q : ptr_q;
  assign mask = (state_q == GRANT) && |(request & ~grant_q);
  rr_priority_picker #(.CHANNELS(CHANNELS)) u_pick (
    .req_i(request), .ptr_i(pick_ptr), .mask_i(mask),
    .win_o(win), .idx_o(win_id), .found_o(found)
  );
  always_comb begin
    rel = (state_q == GRANT) && (rem_q == '0 || !(|(request & grant_q)));
    hold = (state_q == GRANT) && !rel;
    take = ((state_q == IDLE) || rel) && found;
    load = (wrr_en && w_arr[win_id] != '0) ? w_arr[win_id] - WIDTH'(1) : '0;
    grant_d = hold ? grant_q : take ? win : '0;
    id_d = hold ? id_q : take ? win_id : '0;
    rem_d = hold ? rem_q - WIDTH'(1) : take ? load : '0;
    state_d = (hold || take) ? GRANT : IDLE;
    ptr_d = rel ? id_q : ptr_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q <= '0;
      rem_q <= '0;
      ptr_q <= IDW'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q <= id_d;
      rem_q <= rem_d;
      ptr_q <= ptr_d;
    end
  end
  assign grant = grant_q;
  assign grant_id = id_q;
  assign grant_valid = |grant_q;
  assign quantum_last = grant_valid && rem_q == '0;
endmodule

// File: tb/tb_wrr_arbiter_param.sv
// tb_wrr_arbiter_param: vector table, corner sequences and random traffic against a quantum-level reference model
module tb_wrr_arbiter_param;
  localparam int C = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [C-1:0] request = '0;
  logic [C*W-1:0] weight = '0;
  logic wrr_en = 1'b1;
  logic [C-1:0] grant;
  logic [1:0] grant_id;
  logic grant_valid, quantum_last;
  int n_tests = 0;
  int n_fail = 0;
  int m_owner, m_left, m_last;
  typedef struct {
    logic [C-1:0] req;
    logic wrr;
    int id;
    logic ql;
  } vec_t;
  vec_t tv[16];
  wrr_arbiter_param #(.CHANNELS(C), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .request(request), .weight(weight), .wrr_en(wrr_en),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .quantum_last(quantum_last)
  );
  always #5 clk = ~clk;
  function automatic int wt(input int k);
    return int'((weight >> (k * W)) & 32'hFF);
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_left = 0;
    m_last = C - 1;
  endtask
  // quantum measured in whole cycles: the owner keeps the grant while cycles remain and it still requests
  task automatic model_step();
    int k;
    if (m_owner >= 0 && m_left > 1 && request[m_owner]) m_left--;
    else begin
      if (m_owner >= 0) m_last = m_owner;
      m_owner = -1;
      for (int n = 1; n <= C; n++) begin
        k = (m_last + n) % C;
        if (request[k] && m_owner < 0) m_owner = k;
      end
      if (m_owner >= 0) m_left = wrr_en ? ((wt(m_owner) == 0) ? 1 : wt(m_owner)) : 1;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) model_step();
  endtask
  task automatic check_model(input string name);
    chk({name, "_grant"}, 32'(grant), (m_owner >= 0) ? 32'(1) << m_owner : 32'd0);
    chk({name, "_id"}, 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk({name, "_valid"}, 32'(grant_valid), 32'(m_owner >= 0));
    chk({name, "_qlast"}, 32'(quantum_last), 32'(m_owner >= 0 && m_left == 1));
  endtask
  task automatic do_reset();
    reset = 1'b0;
    request = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    weight = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 16; i++) tv[i] = '{4'hF, 1'b0, 0, 1'b1};
    tv[0] = '{4'hF, 1'b1, 0, 1'b1};
    tv[1] = '{4'hF, 1'b1, 1, 1'b0};
    tv[2] = '{4'hF, 1'b1, 1, 1'b1};
    tv[3] = '{4'hF, 1'b1, 2, 1'b0};
    tv[4] = '{4'hF, 1'b1, 2, 1'b0};
    tv[5] = '{4'hF, 1'b1, 2, 1'b1};
    tv[6] = '{4'hF, 1'b1, 3, 1'b0};
    tv[7] = '{4'hF, 1'b1, 3, 1'b0};
    tv[8] = '{4'hF, 1'b1, 3, 1'b0};
    tv[9] = '{4'hF, 1'b1, 3, 1'b1};
    tv[10] = '{4'hF, 1'b1, 0, 1'b1};
    tv[11] = '{4'hF, 1'b0, 1, 1'b1};
    tv[12] = '{4'hF, 1'b0, 2, 1'b1};
    tv[13] = '{4'hF, 1'b0, 3, 1'b1};
    tv[14] = '{4'hF, 1'b0, 0, 1'b1};
    tv[15] = '{4'hF, 1'b0, 1, 1'b1};
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_id", 32'(grant_id), 0);
    chk("rst_valid", 32'(grant_valid), 0);
    chk("rst_qlast", 32'(quantum_last), 0);
    tick();
    chk("idle_grant", 32'(grant), 0);
    for (int i = 0; i < 16; i++) begin
      request = tv[i].req;
      wrr_en = tv[i].wrr;
      tick();
      chk($sformatf("tv%0d_grant", i), 32'(grant), 32'(1) << tv[i].id);
      chk($sformatf("tv%0d_id", i), 32'(grant_id), 32'(tv[i].id));
      chk($sformatf("tv%0d_valid", i), 32'(grant_valid), 1);
      chk($sformatf("tv%0d_qlast", i), 32'(quantum_last), 32'(tv[i].ql));
      check_model($sformatf("tv%0d_m", i));
    end
    wrr_en = 1'b1;
    do_reset();
    request = 4'b0100;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("solo%0d_id", i), 32'(grant_id), 2);
      chk($sformatf("solo%0d_valid", i), 32'(grant_valid), 1);
      chk($sformatf("solo%0d_qlast", i), 32'(quantum_last), 32'(i % 3 == 2));
    end
    do_reset();
    weight = {8'd4, 8'd3, 8'd5, 8'd1};
    request = 4'b0010;
    tick();
    chk("early1_id", 32'(grant_id), 1);
    chk("early1_qlast", 32'(quantum_last), 0);
    request = 4'b1010;
    tick();
    chk("early2_id", 32'(grant_id), 1);
    chk("early2_qlast", 32'(quantum_last), 0);
    request = 4'b1000;
    tick();
    chk("early3_id", 32'(grant_id), 3);
    chk("early3_valid", 32'(grant_valid), 1);
    check_model("early3_m");
    do_reset();
    weight = {8'd4, 8'd3, 8'd2, 8'd0};
    request = 4'b0011;
    tick();
    chk("w0_a_id", 32'(grant_id), 0);
    chk("w0_a_qlast", 32'(quantum_last), 1);
    tick();
    chk("w0_b_id", 32'(grant_id), 1);
    do_reset();
    weight = {8'd4, 8'd3, 8'd2, 8'd1};
    request = 4'b1000;
    tick();
    chk("ar1_id", 32'(grant_id), 3);
    tick();
    chk("ar2_id", 32'(grant_id), 3);
    chk("ar2_qlast", 32'(quantum_last), 0);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("ar_async_grant", 32'(grant), 0);
    chk("ar_async_id", 32'(grant_id), 0);
    chk("ar_async_valid", 32'(grant_valid), 0);
    chk("ar_async_qlast", 32'(quantum_last), 0);
    request = 4'hF;
    tick();
    chk("ar_held_grant", 32'(grant), 0);
    reset = 1'b1;
    tick();
    chk("ar_first_grant", 32'(grant), 1);
    chk("ar_first_id", 32'(grant_id), 0);
    check_model("ar_first_m");
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) weight = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
      if (i % 40 == 0) wrr_en = 1'($urandom_range(0, 3) != 0);
      request = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (request | 4'($urandom & $urandom));
      tick();
      check_model($sformatf("rnd%0d", i));
      chk($sformatf("rnd%0d_onehot", i), 32'($onehot0(grant)), 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wrr_arbiter_param.md
Name: wrr_arbiter_param

Overview:
Parametrised weighted round-robin arbiter; successor to the fixed 8-channel/32-bit RRB.
Grants one requester at a time. The grant is held for a quantum equal to that channel's weight in cycles.
Adds a runtime plain-RR mode, early release on request drop, back-to-back handover with no idle gap, and a binary grant index plus quantum-end strobe.
Sits between channel request sources and the shared resource mux; grant_id drives the mux select directly.

Parameters:
CHANNELS, 8, number of requesters (2..64)
WIDTH, 32, bits per channel weight
IDW, $clog2(CHANNELS), width of grant_id (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
request  input  CHANNELS  per-channel request, level-sensitive
weight  input  CHANNELS*WIDTH  channel k weight at bits [k*WIDTH +: WIDTH]
wrr_en  input  1  1 = weighted quanta, 0 = plain RR (every quantum is 1 cycle)
grant  output  CHANNELS  one-hot grant, registered
grant_id  output  IDW  binary index of granted channel, registered
grant_valid  output  1  high when any grant bit is set
quantum_last  output  1  high during the final cycle of the current quantum

Behaviour:
- Reset (reset=0, async): grant=0, grant_id=0, grant_valid=0, remaining counter=0, state=IDLE, last-winner pointer=CHANNELS-1, so the first search starts at channel 0.
- States: IDLE (no grant) and GRANT (one channel held).
- Winner search: rotating priority starting at pointer+1 and wrapping modulo CHANNELS. Candidates are the bits of the current-cycle request.
- IDLE: if any request bit is set at edge n, grant is registered at edge n+1 (1-cycle latency). Otherwise stay in IDLE.
- Quantum load on every new grant to channel k:
  - wrr_en=1: remaining = weight[k]-1; weight 0 is treated as 1.
  - wrr_en=0: remaining = 0.
  - Weight is sampled only at grant start; later weight or wrr_en changes do not affect the running quantum.
- Each GRANT cycle, release occurs if remaining==0 or request[k]==0 (early release). Otherwise remaining decrements and the grant holds.
- On release:
  - Pointer is set to k.
  - The winner is searched from the same-cycle request with request[k] masked off. If a winner exists, it is registered next cycle (back-to-back, no gap). If not, go to IDLE.
  - Exception: if k is the only requester and request[k] is still 1, k is re-granted with a fresh quantum, no gap.
- Releasing cycle: grant stays asserted during that cycle; it changes at the following edge.
- quantum_last = grant_valid && remaining==0. It is combinational from registers only and does not depend on request. It is not asserted on early release unless remaining==0.
- Invariants:
  - grant is zero or one-hot.
  - grant_id matches the grant bit position.
  - grant_valid == |grant.
  - A channel whose request is low in IDLE is never granted.
- Counter width is WIDTH, with no overflow: it only loads and decrements, and stops at 0.
- Reset asserted mid-quantum clears everything immediately. After deassertion, arbitration restarts from channel 0.

Decomposition:
- Package rrb_pkg:
  - state enum (IDLE, GRANT)
  - one-hot-to-index function
  - weight-slice helper
  - index-width constant derivation
- One combinational sub-module, rr_priority_picker (params CHANNELS). Inputs: request vector, pointer, mask-bit. Outputs: one-hot winner, index, found.
- Top module holds the FSM, the remaining counter, the pointer, and the output registers.

Test Plan:
1. CHANNELS=4, WIDTH=8, wrr_en=1, weights {1,2,3,4} for ch0..3, all requests held. Required: grants ch0 x1, ch1 x2, ch2 x3, ch3 x4, then repeat. No idle cycle between quanta. quantum_last high on each quantum's final cycle.
2. Same setup, wrr_en=0. Required: grant rotates 0,1,2,3,0 one cycle each. quantum_last is high every cycle.
3. Only ch2 requests, weight 3. Required: grant_id=2 continuously; quantum_last pulses every 3rd cycle; no gap on re-grant.
4. ch1 weight 5 granted; drop request[1] on the 2nd grant cycle while ch3 requests. Required: ch3 granted the following cycle. quantum_last is never asserted for the ch1 quantum.
5. Weight 0 on ch0 with ch0 and ch1 requesting. Required: ch0 held exactly 1 cycle, then ch1.
6. Assert reset in the 2nd cycle of a 4-cycle quantum on ch3, then release it with all requests high. Required: outputs go to 0 immediately (async). First grant after release is ch0, one cycle after the first active edge.
